// File: rtl/tone_sequence_ctrl.sv
// Tone sequencer for the 32-bit audio clock divider.
// Selects a note divisor from an 8-entry table, either from the switches
// (manual) or stepping through the table with dwell and gap timing (auto).
// The divisor is only updated while the divider is held in reset.
module tone_sequence_ctrl #(
  parameter int unsigned DWELL_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES   = 2500000,
  parameter int unsigned NUM_STEPS    = 8
) (
  input  logic        inclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  input  logic        loop_en,
  input  logic [2:0]  note_sel,
  output logic [31:0] div_clk_count,
  output logic        div_reset_n,
  output logic        audio_en,
  output logic        busy,
  output logic [2:0]  step_idx,
  output logic        step_done,
  output logic        seq_done
);

  localparam int unsigned DIV_W   = 32;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]   STEP_LAST  = IDX_W'(NUM_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               mode_q, mode_d;
  logic [DIV_W-1:0]   div_count_q, div_count_d;
  logic [IDX_W-1:0]   step_idx_q, step_idx_d;
  logic               div_reset_n_q, div_reset_n_d;
  logic               audio_en_q, audio_en_d;
  logic               busy_q, busy_d;
  logic               step_done_q, step_done_d;
  logic               seq_done_q, seq_done_d;

  logic               abort;
  logic               load;
  logic [IDX_W-1:0]   load_idx;

  // Half-period counts at 50 MHz for the eight notes.
  function automatic logic [DIV_W-1:0] note_div(input logic [IDX_W-1:0] idx);
    logic [DIV_W-1:0] val;
    case (idx)
      3'd0:    val = 32'd95557;
      3'd1:    val = 32'd85131;
      3'd2:    val = 32'd75843;
      3'd3:    val = 32'd71586;
      3'd4:    val = 32'd63776;
      3'd5:    val = 32'd56818;
      3'd6:    val = 32'd50619;
      default: val = 32'd47778;
    endcase
    return val;
  endfunction

  // State, counters and registered outputs.
  always_ff @(posedge inclk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      dwell_q       <= '0;
      gap_q         <= '0;
      mode_q        <= 1'b0;
      div_count_q   <= 32'd95557;
      step_idx_q    <= '0;
      div_reset_n_q <= 1'b0;
      audio_en_q    <= 1'b0;
      busy_q        <= 1'b0;
      step_done_q   <= 1'b0;
      seq_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      gap_q         <= gap_d;
      mode_q        <= mode_d;
      div_count_q   <= div_count_d;
      step_idx_q    <= step_idx_d;
      div_reset_n_q <= div_reset_n_d;
      audio_en_q    <= audio_en_d;
      busy_q        <= busy_d;
      step_done_q   <= step_done_d;
      seq_done_q    <= seq_done_d;
    end
  end

  // Next-state logic; outputs are derived from the state being entered.
  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    gap_d       = gap_q;
    mode_d      = mode_q;
    div_count_d = div_count_q;
    step_idx_d  = step_idx_q;
    step_done_d = 1'b0;
    load        = 1'b0;
    load_idx    = step_idx_q;

    abort = (state_q != S_IDLE) && (stop || !enable);

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && enable && !stop) begin
            load     = 1'b1;
            load_idx = mode ? '0 : note_sel;
          end
        end
        S_LOAD: begin
          state_d = S_PLAY;
          dwell_d = '0;
        end
        S_PLAY: begin
          if (!mode_q) begin
            if (note_sel != step_idx_q) begin
              load     = 1'b1;
              load_idx = note_sel;
            end
          end else if (dwell_q == DWELL_LAST) begin
            step_done_d = 1'b1;
            state_d     = S_GAP;
            gap_d       = '0;
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (step_idx_q < STEP_LAST) begin
              load     = 1'b1;
              load_idx = step_idx_q + IDX_W'(1);
            end else if (loop_en) begin
              load     = 1'b1;
              load_idx = '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (load) begin
        state_d     = S_LOAD;
        step_idx_d  = load_idx;
        div_count_d = note_div(load_idx);
        mode_d      = mode;
      end
    end

    div_reset_n_d = (state_d == S_PLAY);
    audio_en_d    = (state_d == S_PLAY);
    busy_d        = (state_d != S_IDLE);
    seq_done_d    = (state_d == S_DONE);
  end

  assign div_clk_count = div_count_q;
  assign div_reset_n   = div_reset_n_q;
  assign audio_en      = audio_en_q;
  assign busy          = busy_q;
  assign step_idx      = step_idx_q;
  assign step_done     = step_done_q;
  assign seq_done      = seq_done_q;

endmodule

// File: tb/tb_tone_sequence_ctrl.sv
// Directed bench for tone_sequence_ctrl with short dwell/gap timing.
module tb_tone_sequence_ctrl;

  logic        inclk;
  logic        reset;
  logic        enable;
  logic        start;
  logic        stop;
  logic        mode;
  logic        loop_en;
  logic [2:0]  note_sel;
  logic [31:0] div_clk_count;
  logic        div_reset_n;
  logic        audio_en;
  logic        busy;
  logic [2:0]  step_idx;
  logic        step_done;
  logic        seq_done;

  int n_checks;
  int n_fails;
  logic [31:0] note_tab [8];

  tone_sequence_ctrl #(
    .DWELL_CYCLES (10),
    .GAP_CYCLES   (2),
    .NUM_STEPS    (8)
  ) dut (
    .inclk         (inclk),
    .reset         (reset),
    .enable        (enable),
    .start         (start),
    .stop          (stop),
    .mode          (mode),
    .loop_en       (loop_en),
    .note_sel      (note_sel),
    .div_clk_count (div_clk_count),
    .div_reset_n   (div_reset_n),
    .audio_en      (audio_en),
    .busy          (busy),
    .step_idx      (step_idx),
    .step_done     (step_done),
    .seq_done      (seq_done)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int t;
    int pulses;
    int seqs;
    int last_pulse;
    int sd_count;

    n_checks = 0;
    n_fails  = 0;
    note_tab[0] = 32'd95557; note_tab[1] = 32'd85131;
    note_tab[2] = 32'd75843; note_tab[3] = 32'd71586;
    note_tab[4] = 32'd63776; note_tab[5] = 32'd56818;
    note_tab[6] = 32'd50619; note_tab[7] = 32'd47778;

    reset = 1'b0; enable = 1'b1; start = 1'b0; stop = 1'b0;
    mode = 1'b0; loop_en = 1'b0; note_sel = 3'd0;

    // Power-on reset
    tick(); tick();
    chk("rst_div", div_clk_count, 32'd95557);
    chk("rst_divrn", 32'(div_reset_n), 32'd0);
    chk("rst_audio", 32'(audio_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(step_idx), 32'd0);
    chk("rst_sdone", 32'(step_done), 32'd0);
    chk("rst_seqdone", 32'(seq_done), 32'd0);
    reset = 1'b1;
    tick();

    // Manual mode: note 5, then switch to note 2
    mode = 1'b0; note_sel = 3'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("man_load_busy", 32'(busy), 32'd1);
    chk("man_load_div", div_clk_count, 32'd56818);
    chk("man_load_divrn", 32'(div_reset_n), 32'd0);
    chk("man_load_idx", 32'(step_idx), 32'd5);
    tick();
    chk("man_play_divrn", 32'(div_reset_n), 32'd1);
    chk("man_play_audio", 32'(audio_en), 32'd1);
    tick(); tick();
    chk("man_hold_div", div_clk_count, 32'd56818);
    note_sel = 3'd2;
    tick();
    chk("man_reload_divrn", 32'(div_reset_n), 32'd0);
    chk("man_reload_div", div_clk_count, 32'd75843);
    chk("man_reload_idx", 32'(step_idx), 32'd2);
    tick();
    chk("man_replay_divrn", 32'(div_reset_n), 32'd1);
    chk("man_replay_div", div_clk_count, 32'd75843);
    sd_count = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (step_done) sd_count++;
    end
    chk("man_no_stepdone", 32'(sd_count), 32'd0);
    chk("man_still_play", 32'(audio_en), 32'd1);

    // Reset while playing
    reset = 1'b0;
    tick(); tick();
    chk("midrst_div", div_clk_count, 32'd95557);
    chk("midrst_divrn", 32'(div_reset_n), 32'd0);
    chk("midrst_audio", 32'(audio_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_idx", 32'(step_idx), 32'd0);
    reset = 1'b1;
    tick();

    // Auto mode, single pass
    mode = 1'b1; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("auto_load_idx", 32'(step_idx), 32'd0);
    chk("auto_load_div", div_clk_count, 32'd95557);
    t = 0; pulses = 0; seqs = 0; last_pulse = 0;
    while (t < 200 && busy) begin
      tick();
      t++;
      if (step_done) begin
        if (pulses < 8) begin
          chk("auto_step_idx", 32'(step_idx), 32'(pulses));
          chk("auto_step_div", div_clk_count, note_tab[pulses]);
        end
        if (pulses == 0) chk("auto_first_done", 32'(t), 32'd11);
        else chk("auto_spacing", 32'(t - last_pulse), 32'd13);
        last_pulse = t;
        pulses++;
      end
      if (seq_done) seqs++;
    end
    chk("auto_pulses", 32'(pulses), 32'd8);
    chk("auto_seqdone", 32'(seqs), 32'd1);
    chk("auto_idle_cycle", 32'(t), 32'd105);
    chk("auto_end_busy", 32'(busy), 32'd0);
    chk("auto_end_divrn", 32'(div_reset_n), 32'd0);

    // Auto mode with looping
    loop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0; seqs = 0;
    for (int c = 1; c <= 104; c++) begin
      tick();
      if (step_done) pulses++;
      if (seq_done) seqs++;
      if (c == 103) chk("loop_last_idx", 32'(step_idx), 32'd7);
      if (c == 104) begin
        chk("loop_wrap_idx", 32'(step_idx), 32'd0);
        chk("loop_wrap_div", div_clk_count, 32'd95557);
        chk("loop_wrap_divrn", 32'(div_reset_n), 32'd0);
        chk("loop_wrap_busy", 32'(busy), 32'd1);
      end
    end
    tick();
    chk("loop_replay_divrn", 32'(div_reset_n), 32'd1);
    chk("loop_pulses", 32'(pulses), 32'd8);
    chk("loop_no_seqdone", 32'(seqs), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("loop_stop_busy", 32'(busy), 32'd0);

    // Abort with stop during step 3 PLAY
    loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (44) tick();
    chk("abort_pre_idx", 32'(step_idx), 32'd3);
    chk("abort_pre_divrn", 32'(div_reset_n), 32'd1);
    stop = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_divrn", 32'(div_reset_n), 32'd0);
    chk("abort_audio", 32'(audio_en), 32'd0);
    start = 1'b1;
    tick();
    chk("startstop_busy", 32'(busy), 32'd0);
    tick();
    chk("startstop_busy2", 32'(busy), 32'd0);
    chk("startstop_idx", 32'(step_idx), 32'd3);
    stop = 1'b0; start = 1'b0;

    // Start ignored while disabled
    enable = 1'b0; start = 1'b1;
    tick(); tick();
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_idx", 32'(step_idx), 32'd3);
    chk("dis_divrn", 32'(div_reset_n), 32'd0);
    start = 1'b0; enable = 1'b1;
    tick();

    // Drop enable during GAP
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    chk("gap_stepdone", 32'(step_done), 32'd1);
    chk("gap_audio", 32'(audio_en), 32'd0);
    chk("gap_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    tick();
    chk("gap_dis_busy", 32'(busy), 32'd0);
    tick();
    chk("gap_dis_stay", 32'(busy), 32'd0);
    enable = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
